// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states and
// datapath mux select values used by the sequencer, the datapath and the bench.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_LUIWB  = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_JAL    = 4'd13,
    S_JR     = 4'd14,
    S_TRAP   = 4'd15
  } state_e;

  localparam logic [1:0] PCSRC_SEQ    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] ALUB_RT      = 2'd0;
  localparam logic [1:0] ALUB_FOUR    = 2'd1;
  localparam logic [1:0] ALUB_IMM     = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

  localparam logic [1:0] ALUOP_ADD    = 2'd0;
  localparam logic [1:0] ALUOP_SUB    = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT  = 2'd2;
  localparam logic [1:0] ALUOP_IMM    = 2'd3;

  localparam logic [1:0] REGDST_RT    = 2'd0;
  localparam logic [1:0] REGDST_RD    = 2'd1;
  localparam logic [1:0] REGDST_RA    = 2'd2;

  localparam logic [1:0] WB_ALUOUT    = 2'd0;
  localparam logic [1:0] WB_MDR       = 2'd1;
  localparam logic [1:0] WB_PC        = 2'd2;
  localparam logic [1:0] WB_LUI       = 2'd3;

  // States that wait on the memory handshake and are therefore subject to timeout.
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts stalled cycles in a memory state and flags the cycle
// whose increment would reach the configured limit. A limit of 0 disables the timeout.
module mc_wait_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic wait_en,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC);

  logic [7:0] count_q;
  logic [7:0] count_d;
  logic [7:0] count_inc;

  always_comb begin
    count_inc = count_q + 8'd1;
    count_d   = count_q;
    if (clear) begin
      count_d = '0;
    end else if (wait_en && (count_q != 8'hFF)) begin
      count_d = count_inc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout = (LIMIT != 8'd0) && wait_en && (count_inc == LIMIT);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS sequencer: Moore FSM stepping each instruction through fetch,
// decode, execute, memory and write-back, with memory stalls and a sticky trap.
module mc_ctrl_fsm
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       ExtOp,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] WBSel,
  output logic       trap,
  output logic [3:0] state_dbg
);

  state_e state_q;
  state_e state_d;
  logic   in_mem;
  logic   timeout;

  assign in_mem = is_mem_state(state_q);

  // Every memory state is entered from a non-memory state or left on mem_ready,
  // so clearing outside memory states also covers "clear on entry".
  mc_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (!in_mem || mem_ready),
    .wait_en(in_mem && !mem_ready),
    .timeout(timeout)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                         state_d = (funct == FN_JR) ? S_JR : S_EXEC;
          OP_LW, OP_SW:                     state_d = S_MEMADR;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
          OP_LUI:                           state_d = S_LUIWB;
          OP_J:                             state_d = S_JUMP;
          OP_JAL:                           state_d = S_JAL;
          default:                          state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_TRAP;
      end
      S_MEMWR: begin
        if (mem_ready)    state_d = S_FETCH;
        else if (timeout) state_d = S_TRAP;
      end
      S_EXEC:  state_d = S_RWB;
      S_IEXEC: state_d = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_LUIWB, S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_comb begin
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = PCSRC_SEQ;
    ALUSrcA  = 1'b0;
    ALUSrcB  = ALUB_RT;
    ALUOp    = ALUOP_ADD;
    ExtOp    = 1'b0;
    RegWrite = 1'b0;
    RegDst   = REGDST_RT;
    WBSel    = WB_ALUOUT;
    trap     = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = ALUB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        // Branch target precompute needs the sign-extended offset.
        ALUSrcB = ALUB_IMM_SH2;
        ExtOp   = 1'b1;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUB_IMM;
        ExtOp   = 1'b1;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        WBSel    = WB_MDR;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = REGDST_RD;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUB_IMM;
        ALUOp   = ALUOP_IMM;
        ExtOp   = !((opcode == OP_ANDI) || (opcode == OP_ORI));
      end
      S_IWB: begin
        RegWrite = 1'b1;
      end
      S_LUIWB: begin
        RegWrite = 1'b1;
        WBSel    = WB_LUI;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_SUB;
        PCSrc   = PCSRC_ALUOUT;
        PCWrite = (opcode == OP_BEQ) ? zero : !zero;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = PCSRC_JUMP;
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSrc    = PCSRC_JUMP;
        RegWrite = 1'b1;
        RegDst   = REGDST_RA;
        WBSel    = WB_PC;
      end
      S_JR: begin
        PCWrite = 1'b1;
        PCSrc   = PCSRC_RS;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: ;
    endcase
    // While reset is held the FSM sits in FETCH but must not strobe memory.
    if (reset) begin
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = PCSRC_SEQ;
      ALUSrcA  = 1'b0;
      ALUSrcB  = ALUB_RT;
      ALUOp    = ALUOP_ADD;
      ExtOp    = 1'b0;
      RegWrite = 1'b0;
      RegDst   = REGDST_RT;
      WBSel    = WB_ALUOUT;
      trap     = 1'b0;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: stimulus pushes hand-computed per-cycle output
// vectors into a queue; a negedge monitor pops and compares them against the DUT.
module tb_mc_ctrl_fsm;
  import mips_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       MemRead, MemWrite, IorD, IRWrite, PCWrite, ALUSrcA, ExtOp, RegWrite, trap;
  logic [1:0] PCSrc, ALUSrcB, ALUOp, RegDst, WBSel;
  logic [3:0] state_dbg;

  mc_ctrl_fsm #(
    .TIMEOUT_CYC(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .opcode   (opcode),
    .funct    (funct),
    .zero     (zero),
    .mem_ready(mem_ready),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IorD     (IorD),
    .IRWrite  (IRWrite),
    .PCWrite  (PCWrite),
    .PCSrc    (PCSrc),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .ExtOp    (ExtOp),
    .RegWrite (RegWrite),
    .RegDst   (RegDst),
    .WBSel    (WBSel),
    .trap     (trap),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] st;
    logic       mr, mw, iord, irw, pcw;
    logic [1:0] pcsrc;
    logic       asa;
    logic [1:0] asb, aluop;
    logic       ext, rw;
    logic [1:0] rd, wb;
    logic       trp;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] st,
                              input logic mr, input logic mw, input logic iord,
                              input logic irw, input logic pcw, input logic [1:0] pcsrc,
                              input logic asa, input logic [1:0] asb, input logic [1:0] aluop,
                              input logic ext, input logic rw, input logic [1:0] rd,
                              input logic [1:0] wb, input logic trp);
    vec_t v;
    v.st = st; v.mr = mr; v.mw = mw; v.iord = iord; v.irw = irw; v.pcw = pcw;
    v.pcsrc = pcsrc; v.asa = asa; v.asb = asb; v.aluop = aluop; v.ext = ext;
    v.rw = rw; v.rd = rd; v.wb = wb; v.trp = trp;
    return v;
  endfunction

  vec_t act;
  assign act = vec_t'({state_dbg, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc, ALUSrcA,
                       ALUSrcB, ALUOp, ExtOp, RegWrite, RegDst, WBSel, trap});

  vec_t  exp_q[$];
  string tag_q[$];
  int    checks   = 0;
  int    failures = 0;

  //              st  mr mw io irw pcw pcs asa asb op ext rw rd wb trp
  vec_t V_RST   = mk(0,  0, 0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0, 0);
  vec_t V_FWAIT = mk(0,  1, 0, 0, 0, 0,  0,  0,  1, 0, 0,  0, 0, 0, 0);
  vec_t V_FRDY  = mk(0,  1, 0, 0, 1, 1,  0,  0,  1, 0, 0,  0, 0, 0, 0);
  vec_t V_DEC   = mk(1,  0, 0, 0, 0, 0,  0,  0,  3, 0, 1,  0, 0, 0, 0);
  vec_t V_MADR  = mk(2,  0, 0, 0, 0, 0,  0,  1,  2, 0, 1,  0, 0, 0, 0);
  vec_t V_MRD   = mk(3,  1, 0, 1, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0, 0);
  vec_t V_MWB   = mk(4,  0, 0, 0, 0, 0,  0,  0,  0, 0, 0,  1, 0, 1, 0);
  vec_t V_MWR   = mk(5,  0, 1, 1, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0, 0);
  vec_t V_EXEC  = mk(6,  0, 0, 0, 0, 0,  0,  1,  0, 2, 0,  0, 0, 0, 0);
  vec_t V_RWB   = mk(7,  0, 0, 0, 0, 0,  0,  0,  0, 0, 0,  1, 1, 0, 0);
  vec_t V_IEXZ  = mk(8,  0, 0, 0, 0, 0,  0,  1,  2, 3, 0,  0, 0, 0, 0);
  vec_t V_IEXS  = mk(8,  0, 0, 0, 0, 0,  0,  1,  2, 3, 1,  0, 0, 0, 0);
  vec_t V_IWB   = mk(9,  0, 0, 0, 0, 0,  0,  0,  0, 0, 0,  1, 0, 0, 0);
  vec_t V_LUI   = mk(10, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0,  1, 0, 3, 0);
  vec_t V_BR1   = mk(11, 0, 0, 0, 0, 1,  1,  1,  0, 1, 0,  0, 0, 0, 0);
  vec_t V_BR0   = mk(11, 0, 0, 0, 0, 0,  1,  1,  0, 1, 0,  0, 0, 0, 0);
  vec_t V_J     = mk(12, 0, 0, 0, 0, 1,  2,  0,  0, 0, 0,  0, 0, 0, 0);
  vec_t V_JAL   = mk(13, 0, 0, 0, 0, 1,  2,  0,  0, 0, 0,  1, 2, 2, 0);
  vec_t V_JR    = mk(14, 0, 0, 0, 0, 1,  3,  0,  0, 0, 0,  0, 0, 0, 0);
  vec_t V_TRAP  = mk(15, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0, 1);

  vec_t  mon_e;
  string mon_t;

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      checks++;
      if (act !== mon_e) begin
        failures++;
        $display("FAIL %s got=%h want=%h (state got=%0d want=%0d)", mon_t, act, mon_e,
                 act.st, mon_e.st);
      end else begin
        $display("ok   %s state=%0d", mon_t, act.st);
      end
    end
  end

  task automatic expect_vec(input vec_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic step(input logic mr, input logic z, input vec_t e, input string t);
    @(posedge clock);
    #1;
    mem_ready = mr;
    zero      = z;
    expect_vec(e, t);
  endtask

  task automatic new_instr(input logic [5:0] op, input logic [5:0] fn, input string t);
    @(posedge clock);
    #1;
    opcode    = op;
    funct     = fn;
    mem_ready = 1'b1;
    zero      = 1'b0;
    expect_vec(V_FRDY, t);
  endtask

  task automatic do_reset(input string t);
    @(posedge clock);
    #1;
    reset     = 1'b1;
    mem_ready = 1'b0;
    expect_vec(V_RST, t);
    @(posedge clock);
    #1;
    reset = 1'b0;
    expect_vec(V_FWAIT, {t, "_release"});
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 6'h00;
    funct     = 6'h00;
    zero      = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    expect_vec(V_RST, "reset_held");
    @(posedge clock);
    #1;
    reset = 1'b0;
    expect_vec(V_FWAIT, "reset_release");

    // lw with memory always ready: 0,1,2,3,4
    new_instr(OP_LW, 6'h00, "lw_fetch");
    step(1, 0, V_DEC,  "lw_decode");
    step(1, 0, V_MADR, "lw_memadr");
    step(1, 0, V_MRD,  "lw_memrd");
    step(1, 0, V_MWB,  "lw_memwb");

    new_instr(OP_BEQ, 6'h00, "beq_t_fetch");
    step(0, 1, V_DEC, "beq_t_decode");
    step(0, 1, V_BR1, "beq_t_branch");
    new_instr(OP_BEQ, 6'h00, "beq_nt_fetch");
    step(0, 0, V_DEC, "beq_nt_decode");
    step(0, 0, V_BR0, "beq_nt_branch");
    new_instr(OP_BNE, 6'h00, "bne_fetch");
    step(0, 0, V_DEC, "bne_decode");
    step(0, 0, V_BR1, "bne_branch_taken");

    // add with a three-cycle fetch stall
    for (int i = 0; i < 3; i++) step(0, 0, V_FWAIT, "add_fetch_wait");
    new_instr(6'h00, 6'h20, "add_fetch");
    step(1, 0, V_DEC,  "add_decode");
    step(1, 0, V_EXEC, "add_exec");
    step(0, 0, V_RWB,  "add_rwb");

    new_instr(OP_ORI, 6'h00, "ori_fetch");
    step(0, 0, V_DEC,  "ori_decode");
    step(0, 0, V_IEXZ, "ori_iexec");
    step(0, 0, V_IWB,  "ori_iwb");
    new_instr(OP_ADDI, 6'h00, "addi_fetch");
    step(0, 0, V_DEC,  "addi_decode");
    step(0, 0, V_IEXS, "addi_iexec");
    step(0, 0, V_IWB,  "addi_iwb");
    new_instr(OP_LUI, 6'h00, "lui_fetch");
    step(0, 0, V_DEC, "lui_decode");
    step(0, 0, V_LUI, "lui_wb");
    new_instr(OP_JAL, 6'h00, "jal_fetch");
    step(0, 0, V_DEC, "jal_decode");
    step(0, 0, V_JAL, "jal_exec");
    new_instr(6'h00, FN_JR, "jr_fetch");
    step(0, 0, V_DEC, "jr_decode");
    step(0, 0, V_JR,  "jr_exec");
    new_instr(OP_J, 6'h00, "j_fetch");
    step(0, 0, V_DEC, "j_decode");
    step(0, 0, V_J,   "j_exec");

    // illegal opcode: sticky trap regardless of mem_ready
    new_instr(6'h3F, 6'h00, "ill_fetch");
    step(0, 0, V_DEC, "ill_decode");
    for (int i = 0; i < 100; i++) begin
      logic [31:0] iv;
      iv = i;
      step(iv[0], 0, V_TRAP, "ill_trap_hold");
    end
    do_reset("ill_reset");

    // sw with memory stuck: four MEMWR cycles then trap
    new_instr(OP_SW, 6'h00, "sw_fetch");
    step(0, 0, V_DEC,  "sw_decode");
    step(0, 0, V_MADR, "sw_memadr");
    for (int i = 0; i < 4; i++) step(0, 0, V_MWR, "sw_memwr_wait");
    step(0, 0, V_TRAP, "sw_timeout_trap");
    step(1, 0, V_TRAP, "sw_trap_hold");
    do_reset("sw_reset");

    // lw with three read stalls, then reset asserted mid-read
    new_instr(OP_LW, 6'h00, "lw2_fetch");
    step(0, 0, V_DEC,  "lw2_decode");
    step(0, 0, V_MADR, "lw2_memadr");
    for (int i = 0; i < 3; i++) step(0, 0, V_MRD, "lw2_memrd_wait");
    do_reset("lw2_reset_mid_read");

    repeat (3) @(posedge clock);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
